// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled 8N1 serial receiver feeding the RX FIFO.
// Ports: clk, reset (sync, active-high), rx_bit, freq_divider[7:0],
//   fifo_full -> data_out[7:0], push, frame_err, overrun, busy.
// Option: define UART_RX_MAJORITY_EN for 2-of-3 majority sampling.
module uart_rx (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_bit,
    input  logic [7:0] freq_divider,
    input  logic       fifo_full,
    output logic [7:0] data_out,
    output logic       push,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t      state_q, state_d;
    logic        sync1_q, sync1_d;
    logic        sync2_q, sync2_d;
    logic        prev_q, prev_d;
    logic [7:0]  presc_q, presc_d;
    logic [3:0]  tick_cnt_q, tick_cnt_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  data_q, data_d;
    logic        push_q, push_d;
    logic        ferr_q, ferr_d;
    logic        ovr_q, ovr_d;
    logic        tick;
    logic        sample;

`ifdef UART_RX_MAJORITY_EN
    // Samples from the two previous ticks; the vote is taken one tick
    // late so the window straddles the nominal mid-bit point.
    logic [1:0]  hist_q, hist_d;
    localparam logic [3:0] START_DEC = 4'd8;
    assign sample = (hist_q[1] & hist_q[0]) |
                    (hist_q[1] & sync2_q) |
                    (hist_q[0] & sync2_q);
    always_comb begin
        hist_d = hist_q;
        if (tick) hist_d = {hist_q[0], sync2_q};
    end
    always_ff @(posedge clk) begin
        if (reset) hist_q <= 2'b11;
        else       hist_q <= hist_d;
    end
`else
    localparam logic [3:0] START_DEC = 4'd7;
    assign sample = sync2_q;
`endif

    // >= keeps the prescaler wrapping if the divider is lowered.
    assign tick = (presc_q >= freq_divider);

    always_comb begin
        sync1_d    = rx_bit;
        sync2_d    = sync1_q;
        prev_d     = sync2_q;
        presc_d    = tick ? 8'd0 : presc_q + 8'd1;
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        data_d     = data_q;
        push_d     = 1'b0;
        ferr_d     = 1'b0;
        ovr_d      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (prev_q && !sync2_q) begin
                    state_d    = START;
                    tick_cnt_d = 4'd0;
                    bit_idx_d  = 3'd0;
                end
            end
            START: begin
                if (tick) begin
                    if (tick_cnt_q == START_DEC) begin
                        tick_cnt_d = 4'd0;
                        bit_idx_d  = 3'd0;
                        state_d    = sample ? IDLE : DATA;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 4'd1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (tick_cnt_q == 4'd15) begin
                        shift_d[bit_idx_q] = sample;
                        tick_cnt_d = 4'd0;
                        if (bit_idx_q == 3'd7) begin
                            state_d   = STOP;
                            bit_idx_d = 3'd0;
                        end else begin
                            bit_idx_d = bit_idx_q + 3'd1;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 4'd1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (tick_cnt_q == 4'd15) begin
                        state_d    = IDLE;
                        tick_cnt_d = 4'd0;
                        unique case (1'b1)
                            sample && !fifo_full: begin
                                data_d = shift_q;
                                push_d = 1'b1;
                            end
                            sample && fifo_full: ovr_d  = 1'b1;
                            !sample:             ferr_d = 1'b1;
                        endcase
                    end else begin
                        tick_cnt_d = tick_cnt_q + 4'd1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            prev_q     <= 1'b1;
            presc_q    <= 8'd0;
            tick_cnt_q <= 4'd0;
            bit_idx_q  <= 3'd0;
            shift_q    <= 8'd0;
            data_q     <= 8'd0;
            push_q     <= 1'b0;
            ferr_q     <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            prev_q     <= prev_d;
            presc_q    <= presc_d;
            tick_cnt_q <= tick_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            push_q     <= push_d;
            ferr_q     <= ferr_d;
            ovr_q      <= ovr_d;
        end
    end

    assign data_out  = data_q;
    assign push      = push_q;
    assign frame_err = ferr_q;
    assign overrun   = ovr_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx.
// Directed 8N1 frames; a monitor pops expected events per output pulse.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx_bit = 1'b1;
    logic       fifo_full = 1'b0;
    logic [7:0] freq_divider = 8'd0;
    logic [7:0] data_out;
    logic       push;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    uart_rx dut (
        .clk(clk),
        .reset(reset),
        .rx_bit(rx_bit),
        .freq_divider(freq_divider),
        .fifo_full(fifo_full),
        .data_out(data_out),
        .push(push),
        .frame_err(frame_err),
        .overrun(overrun),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // kind: 0 push, 1 frame_err, 2 overrun
    typedef struct packed {
        logic [1:0] kind;
        logic [7:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [7:0] act,
                         input logic [7:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic expect_ev(input logic [1:0] kind, input logic [7:0] d);
        exp_t e;
        e.kind = kind;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic wait_clk(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        rx_bit = 1'b1;
        wait_clk(n);
    endtask

    // Drives one 16-clk/bit frame; pin cycle j is sampled on tick j
    // when freq_divider is 0. 'glitch' inverts one pin cycle.
    task automatic send_frame(input logic [7:0] d, input logic stop,
                              input int glitch, input int ncyc);
        for (int j = 0; j < ncyc && j < 160; j++) begin
            logic v;
            int   b;
            b = j / 16;
            if (b == 0)      v = 1'b0;
            else if (b <= 8) v = d[b-1];
            else             v = stop;
            if (j == glitch) v = ~v;
            rx_bit = v;
            wait_clk(1);
        end
    endtask

    // Monitor: every output pulse must match the head of the queue.
    initial begin
        forever begin
            @(negedge clk);
            if (push || frame_err || overrun) begin
                exp_t       e;
                logic [1:0] k;
                logic [7:0] nev;
                k = push ? 2'd0 : (frame_err ? 2'd1 : 2'd2);
                nev = 8'(push) + 8'(frame_err) + 8'(overrun);
                check("one_pulse", nev, 8'd1);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_event: kind %0d data %h, expected none",
                             k, data_out);
                end else begin
                    e = exp_q.pop_front();
                    check("event_kind", {6'b0, k}, {6'b0, e.kind});
                    check("event_data_out", data_out, e.data);
                    check("busy_at_event", {7'b0, busy}, 8'h00);
                end
            end
        end
    end

    initial begin
        wait_clk(3);
        check("rst_data_out", data_out, 8'h00);
        check("rst_push", {7'b0, push}, 8'h00);
        check("rst_frame_err", {7'b0, frame_err}, 8'h00);
        check("rst_overrun", {7'b0, overrun}, 8'h00);
        check("rst_busy", {7'b0, busy}, 8'h00);
        reset = 1'b0;
        idle(20);

        // basic receive, back-to-back
        expect_ev(2'd0, 8'h55);
        send_frame(8'h55, 1'b1, -1, 160);
        expect_ev(2'd0, 8'hA3);
        send_frame(8'hA3, 1'b1, -1, 160);
        idle(40);
        check("pending_basic", 8'(exp_q.size()), 8'd0);

        // false start: 3-tick glitch at divider 6
        freq_divider = 8'd6;
        idle(20);
        rx_bit = 1'b0;
        wait_clk(10);
        check("false_start_busy_hi", {7'b0, busy}, 8'h01);
        wait_clk(11);
        idle(200);
        check("false_start_busy_lo", {7'b0, busy}, 8'h00);
        freq_divider = 8'd0;
        idle(20);

        // framing error, then break, then good byte
        expect_ev(2'd1, 8'hA3);
        send_frame(8'h3C, 1'b0, -1, 160);
        rx_bit = 1'b0;
        wait_clk(160);
        check("break_busy", {7'b0, busy}, 8'h00);
        wait_clk(160);
        idle(32);
        expect_ev(2'd0, 8'h81);
        send_frame(8'h81, 1'b1, -1, 160);
        idle(40);

        // overrun
        fifo_full = 1'b1;
        expect_ev(2'd2, 8'h81);
        send_frame(8'h7E, 1'b1, -1, 160);
        fifo_full = 1'b0;
        idle(40);
        check("pending_ovr", 8'(exp_q.size()), 8'd0);

        // reset during bit 4 of 0xF0
        send_frame(8'hF0, 1'b1, -1, 88);
        rx_bit = 1'b1;
        reset = 1'b1;
        wait_clk(1);
        reset = 1'b0;
        check("mid_rst_data_out", data_out, 8'h00);
        check("mid_rst_push", {7'b0, push}, 8'h00);
        check("mid_rst_frame_err", {7'b0, frame_err}, 8'h00);
        check("mid_rst_overrun", {7'b0, overrun}, 8'h00);
        check("mid_rst_busy", {7'b0, busy}, 8'h00);
        idle(20);
        expect_ev(2'd0, 8'h12);
        send_frame(8'h12, 1'b1, -1, 160);
        idle(40);

        // 1-tick inverted pulse at the bit-2 sample point of 0x00
`ifdef UART_RX_MAJORITY_EN
        expect_ev(2'd0, 8'h00);
`else
        expect_ev(2'd0, 8'h04);
`endif
        send_frame(8'h00, 1'b1, 56, 160);
        idle(40);

        check("pending_end", 8'(exp_q.size()), 8'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
